// File: rtl/green_led_pkg.sv
// Shared types and constants for the green LED output stage.
// Channel count, per-channel state encoding and counter width helpers.
package green_led_pkg;

  localparam int NUM_LEDS = 9;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    STRETCH = 2'd2
  } led_state_t;

  function automatic int st_cnt_w(input int ticks);
    return $clog2(ticks + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED channel: holds the LED active for a minimum number of
// ticks after the command drops, re-armed by any new rise.
module led_stretch_channel
  import green_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd,
  input  logic tick,
  output logic active
);

  localparam int SW = st_cnt_w(STRETCH_TICKS);

  led_state_t    state, state_n;
  logic [SW-1:0] st_cnt, st_cnt_n;

  // State and stretch counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= OFF;
      st_cnt <= '0;
    end else begin
      state  <= state_n;
      st_cnt <= st_cnt_n;
    end
  end

  // Next state; a rise during stretch beats a same-cycle expiry.
  always_comb begin
    state_n  = state;
    st_cnt_n = st_cnt;
    unique case (state)
      OFF: begin
        if (cmd) state_n = ON;
      end
      ON: begin
        if (!cmd) begin
          state_n  = STRETCH;
          st_cnt_n = SW'(STRETCH_TICKS);
        end
      end
      STRETCH: begin
        if (cmd) begin
          state_n = ON;
        end else if (tick) begin
          if (st_cnt == SW'(1)) begin
            state_n  = OFF;
            st_cnt_n = '0;
          end else begin
            st_cnt_n = st_cnt - SW'(1);
          end
        end
      end
      default: begin
        state_n  = OFF;
        st_cnt_n = '0;
      end
    endcase
  end

  assign active = (state != OFF);

endmodule

// File: rtl/green_led_driver.sv
// Green LED output stage: shared tick prescaler, PWM dimmer,
// global blink phase and per-channel pulse stretchers.
module green_led_driver
  import green_led_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int STRETCH_TICKS = 100,
  parameter int BLINK_TICKS   = 250,
  parameter int PWM_BITS      = 4,
  parameter int DUTY          = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_cmd,
  input  logic [NUM_LEDS-1:0] blink_mask,
  input  logic                dim_en,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int BW = cnt_w(BLINK_TICKS);

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [NUM_LEDS-1:0] active;
  logic [NUM_LEDS-1:0] blink_gate;
  logic [NUM_LEDS-1:0] dim_gate;

  assign tick   = (pre_cnt == PW'(TICK_DIV - 1));
  assign pwm_on = ({1'b0, pwm_cnt} < (PWM_BITS + 1)'(DUTY));

  // Prescaler wrapping every TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Free-running PWM counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink half-period counter and global phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_stretch_channel #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .cmd    (led_cmd[i]),
      .tick   (tick),
      .active (active[i])
    );
  end

  assign blink_gate = ~blink_mask | {NUM_LEDS{blink_phase}};
  assign dim_gate   = dim_en ? {NUM_LEDS{pwm_on}} : '1;

  // Registered LED drive with blink and dim gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= active & blink_gate & dim_gate;
    end
  end

endmodule

// File: tb/tb_green_led_driver.sv
// Scoreboard bench for green_led_driver: three duty variants,
// checked against a tick-counting reference model.
module tb_green_led_driver;
  import green_led_pkg::*;

  localparam int TD = 10;
  localparam int ST = 3;
  localparam int BT = 4;
  localparam int PB = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] led_cmd = '0;
  logic [8:0] blink_mask = '0;
  logic       dim_en = 1'b0;
  logic [8:0] out1, out0, out4;

  always #5 clk = ~clk;

  green_led_driver #(
    .TICK_DIV(TD), .STRETCH_TICKS(ST), .BLINK_TICKS(BT),
    .PWM_BITS(PB), .DUTY(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .led_cmd(led_cmd),
    .blink_mask(blink_mask), .dim_en(dim_en), .led_out(out1)
  );

  green_led_driver #(
    .TICK_DIV(TD), .STRETCH_TICKS(ST), .BLINK_TICKS(BT),
    .PWM_BITS(PB), .DUTY(0)
  ) u_d0 (
    .clk(clk), .reset_n(reset_n), .led_cmd(led_cmd),
    .blink_mask(blink_mask), .dim_en(dim_en), .led_out(out0)
  );

  green_led_driver #(
    .TICK_DIV(TD), .STRETCH_TICKS(ST), .BLINK_TICKS(BT),
    .PWM_BITS(PB), .DUTY(4)
  ) u_d4 (
    .clk(clk), .reset_n(reset_n), .led_cmd(led_cmd),
    .blink_mask(blink_mask), .dim_en(dim_en), .led_out(out4)
  );

  typedef struct packed {
    logic [8:0] d1;
    logic [8:0] d0;
    logic [8:0] d4;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int         n;
  int         last_on[9];
  logic [8:0] act_prev;
  logic       phase;
  int         pcnt;
  logic [8:0] base;
  exp_t       e_new;
  exp_t       e_got;

  // Ticks occurring on edges a..b (edge e ticks when e mod TD == TD-1).
  function automatic int ticks_in(input int a, input int b);
    if (a > b) return 0;
    return (b + 1) / TD - a / TD;
  endfunction

  // Reference model: one expectation per clock edge.
  initial begin
    n = 0;
    act_prev = '0;
    for (int i = 0; i < 9; i++) last_on[i] = -1;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        n = 0;
        act_prev = '0;
        for (int i = 0; i < 9; i++) last_on[i] = -1;
        sb.push_back('0);
      end else begin
        phase = (((n / TD) / BT) % 2) == 0;
        pcnt  = n % (1 << PB);
        base  = act_prev & (~blink_mask | {9{phase}});
        e_new.d4 = base;
        e_new.d0 = dim_en ? 9'h000 : base;
        e_new.d1 = (dim_en && pcnt >= 1) ? 9'h000 : base;
        sb.push_back(e_new);
        for (int i = 0; i < 9; i++) begin
          if (led_cmd[i]) begin
            last_on[i]  = n;
            act_prev[i] = 1'b1;
          end else begin
            act_prev[i] = (last_on[i] >= 0) &&
                          (ticks_in(last_on[i] + 2, n) < ST);
          end
        end
        n++;
      end
    end
  end

  task automatic check(input string nm, input logic [8:0] got,
                       input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e_got = sb.pop_front();
        if (!reset_n) e_got = '0;
        check("duty1", out1, e_got.d1);
        check("duty0", out0, e_got.d0);
        check("duty4", out4, e_got.d4);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    reset_n = 1'b0;
    led_cmd = 9'h1FF;
    cycles(3);
    reset_n = 1'b1;
    cycles(5);
    led_cmd = 9'h000;
    cycles(40);

    led_cmd = 9'h001;
    cycles(1);
    led_cmd = 9'h000;
    cycles(40);

    led_cmd = 9'h008;
    cycles(5);
    led_cmd = 9'h000;
    cycles(15);
    led_cmd = 9'h008;
    cycles(5);
    led_cmd = 9'h000;
    cycles(40);

    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    blink_mask = 9'h002;
    led_cmd = 9'h002;
    cycles(170);
    led_cmd = 9'h000;
    blink_mask = 9'h000;
    cycles(40);

    dim_en = 1'b1;
    led_cmd = 9'h001;
    cycles(20);
    led_cmd = 9'h000;
    dim_en = 1'b0;
    cycles(40);

    blink_mask = 9'h020;
    led_cmd = 9'h024;
    cycles(10);
    led_cmd = 9'h020;
    cycles(5);
    reset_n = 1'b0;
    cycles(2);
    led_cmd = 9'h000;
    blink_mask = 9'h000;
    reset_n = 1'b1;
    cycles(40);

    repeat (3000) begin
      if ($urandom_range(0, 7) == 0)
        led_cmd = led_cmd ^ 9'(1 << $urandom_range(0, 8));
      if ($urandom_range(0, 63) == 0)
        blink_mask = 9'($urandom);
      if ($urandom_range(0, 63) == 0)
        dim_en = 1'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
      end
      cycles(1);
    end

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
